// File: rtl/mem_dma_engine_pkg.sv
// Shared types for the memory DMA engine: FSM state encoding and mode constants.
package mem_dma_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma_engine_range_chk.sv
// Combinational operand check: flags an empty transfer and any range that would run past the memory.
module mem_dma_engine_range_chk
  import mem_dma_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                  mode,
  input  logic [ADDR_WIDTH-3:0] src_idx,
  input  logic [ADDR_WIDTH-3:0] dst_idx,
  input  logic [ADDR_WIDTH-2:0] length,
  output logic                  zero_len,
  output logic                  range_err
);

  localparam logic [ADDR_WIDTH-1:0] LIMIT = MEM_WORDS[ADDR_WIDTH-1:0];

  // One extra bit of headroom so index+length never overflows the compare.
  logic [ADDR_WIDTH-1:0] dst_end;
  logic [ADDR_WIDTH-1:0] src_end;

  assign dst_end   = {2'b00, dst_idx} + {1'b0, length};
  assign src_end   = {2'b00, src_idx} + {1'b0, length};
  assign zero_len  = (length == '0);
  assign range_err = (dst_end > LIMIT) || ((mode == MODE_COPY) && (src_end > LIMIT));

endmodule

// File: rtl/mem_dma_engine.sv
// Block COPY/FILL engine driving one read and one write port of a single-cycle memory,
// with a completion pulse and an additive checksum of every word written.
module mem_dma_engine
  import mem_dma_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-3:0] src_idx,
  input  logic [ADDR_WIDTH-3:0] dst_idx,
  input  logic [ADDR_WIDTH-2:0] length,
  input  logic [31:0]           fill_data,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           checksum,
  output logic [ADDR_WIDTH-1:0] Waddr,
  output logic                  Wren,
  output logic [31:0]           Wdata,
  output logic [ADDR_WIDTH-1:0] Raddr,
  output logic                  Rden,
  input  logic [31:0]           Rdata
);

  localparam int IW = ADDR_WIDTH - 2;

  state_t           state;
  logic             mode_q;
  logic [IW-1:0]    src_q;
  logic [IW-1:0]    dst_q;
  logic [IW:0]      remaining;
  logic             abort_pend;
  logic             zero_len;
  logic             range_err;
  logic             last_word;

  mem_dma_engine_range_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_range_chk (
    .mode      (mode),
    .src_idx   (src_idx),
    .dst_idx   (dst_idx),
    .length    (length),
    .zero_len  (zero_len),
    .range_err (range_err)
  );

  // An abort seen during READ is held so the following WRITE still completes the word.
  assign last_word = (remaining == {{IW{1'b0}}, 1'b1}) || abort || abort_pend;

  // NOTE: every state and port register uses <= so all of them update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= MODE_COPY;
      src_q      <= '0;
      dst_q      <= '0;
      remaining  <= '0;
      abort_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      checksum   <= '0;
      Waddr      <= '0;
      Wren       <= 1'b0;
      Wdata      <= '0;
      Raddr      <= '0;
      Rden       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q     <= mode;
            src_q      <= src_idx;
            dst_q      <= dst_idx;
            remaining  <= length;
            abort_pend <= 1'b0;
            checksum   <= '0;
            error      <= range_err;
            busy       <= 1'b1;
            if (zero_len || range_err) begin
              state <= ST_FINISH;
              done  <= 1'b1;
            end else if (mode == MODE_COPY) begin
              state <= ST_READ;
              Rden  <= 1'b1;
              Raddr <= {2'b00, src_idx};
            end else begin
              state <= ST_WRITE;
              Wren  <= 1'b1;
              Waddr <= {2'b00, dst_idx};
              Wdata <= fill_data;
            end
          end
        end

        ST_READ: begin
          Rden  <= 1'b0;
          Raddr <= '0;
          Wdata <= Rdata;
          Wren  <= 1'b1;
          Waddr <= {2'b00, dst_q};
          state <= ST_WRITE;
          if (abort) abort_pend <= 1'b1;
        end

        ST_WRITE: begin
          checksum  <= checksum + Wdata;
          src_q     <= src_q + 1'b1;
          dst_q     <= dst_q + 1'b1;
          remaining <= remaining - 1'b1;
          if (last_word) begin
            state <= ST_FINISH;
            Wren  <= 1'b0;
            Waddr <= '0;
            done  <= 1'b1;
          end else if (mode_q == MODE_COPY) begin
            state <= ST_READ;
            Wren  <= 1'b0;
            Waddr <= '0;
            Rden  <= 1'b1;
            Raddr <= {2'b00, src_q + 1'b1};
          end else begin
            Waddr <= {2'b00, dst_q + 1'b1};
          end
        end

        ST_FINISH: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine with a single-cycle memory model and hand-computed expectations.
module tb_mem_dma_engine;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-3:0] src_idx;
  logic [AW-3:0] dst_idx;
  logic [AW-2:0] length;
  logic [31:0]   fill_data;
  logic          abort;
  logic          busy;
  logic          done;
  logic          error;
  logic [31:0]   checksum;
  logic [AW-1:0] Waddr;
  logic          Wren;
  logic [31:0]   Wdata;
  logic [AW-1:0] Raddr;
  logic          Rden;
  logic [31:0]   Rdata;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  int done_cyc, wr_cnt, rd_cnt, both_cnt, act_cnt;

  mem_dma_engine #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src_idx   (src_idx),
    .dst_idx   (dst_idx),
    .length    (length),
    .fill_data (fill_data),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum),
    .Waddr     (Waddr),
    .Wren      (Wren),
    .Wdata     (Wdata),
    .Raddr     (Raddr),
    .Rden      (Rden),
    .Rdata     (Rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (Wren) mem[Waddr[7:0]] <= Wdata;
  end

  assign Rdata = mem[Raddr[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle; returns at the first negedge after the accepting edge.
  task automatic launch(input logic m, input int src, input int dst, input int len, input logic [31:0] data);
    @(negedge clk);
    mode      = m;
    src_idx   = src[AW-3:0];
    dst_idx   = dst[AW-3:0];
    length    = len[AW-2:0];
    fill_data = data;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Samples every negedge until done; optionally raises abort for one cycle at sample abort_at.
  task automatic wait_done(input int abort_at);
    done_cyc = 0; wr_cnt = 0; rd_cnt = 0; both_cnt = 0; act_cnt = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (Wren) wr_cnt++;
      if (Rden) rd_cnt++;
      if (Wren && Rden) both_cnt++;
      if (busy && !done) act_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      abort = (cyc == abort_at);
      @(negedge clk);
    end
    abort = 1'b0;
    if (done_cyc == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3;
    for (int i = 0; i < 8; i++) begin
      mem[40+i] = 32'h100 + i;
      mem[60+i] = 32'hA5A5_0000 + i;
    end
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_idx = '0; dst_idx = '0;
    length = '0; fill_data = '0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wren_rden", {30'd0, Wren, Rden}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;

    // FILL 4 words of 0xDEADBEEF at 8
    launch(1'b1, 0, 8, 4, 32'hDEADBEEF);
    wait_done(0);
    check("fill_done_cyc", done_cyc, 32'd5);
    check("fill_wren_cnt", wr_cnt, 32'd4);
    check("fill_active", act_cnt, 32'd4);
    check("fill_checksum", checksum, 32'h7AB6FBBC);
    check("fill_mem8", mem[8], 32'hDEADBEEF);
    check("fill_mem11", mem[11], 32'hDEADBEEF);
    check("fill_mem12", mem[12], 32'h0);
    @(negedge clk);
    check("fill_idle_busy_done", {30'd0, busy, done}, 32'd0);
    check("fill_checksum_hold", checksum, 32'h7AB6FBBC);

    // COPY 1,2,3 from 0 to 20
    launch(1'b0, 0, 20, 3, 32'h0);
    wait_done(0);
    check("copy_done_cyc", done_cyc, 32'd7);
    check("copy_rd_cnt", rd_cnt, 32'd3);
    check("copy_wr_cnt", wr_cnt, 32'd3);
    check("copy_overlap", both_cnt, 32'd0);
    check("copy_active", act_cnt, 32'd6);
    check("copy_checksum", checksum, 32'd6);
    check("copy_mem20", mem[20], 32'd1);
    check("copy_mem22", mem[22], 32'd3);

    // Zero length
    launch(1'b1, 0, 30, 0, 32'h12345678);
    wait_done(0);
    check("zero_done_cyc", done_cyc, 32'd1);
    check("zero_access", wr_cnt + rd_cnt, 32'd0);
    check("zero_error", {31'd0, error}, 32'd0);
    check("zero_checksum", checksum, 32'd0);

    // FILL past the end
    launch(1'b1, 0, 250, 10, 32'hCAFEF00D);
    wait_done(0);
    check("oor_done_cyc", done_cyc, 32'd1);
    check("oor_error", {31'd0, error}, 32'd1);
    check("oor_no_write", wr_cnt, 32'd0);
    check("oor_mem250", mem[250], 32'h0);
    repeat (2) @(negedge clk);
    check("oor_error_sticky", {31'd0, error}, 32'd1);

    // FILL ending exactly at the last word
    launch(1'b1, 0, 252, 4, 32'h11111111);
    wait_done(0);
    check("edge_error", {31'd0, error}, 32'd0);
    check("edge_wr_cnt", wr_cnt, 32'd4);
    check("edge_mem255", mem[255], 32'h11111111);
    check("edge_checksum", checksum, 32'h44444444);

    // COPY with source range past the end
    launch(1'b0, 250, 0, 10, 32'h0);
    wait_done(0);
    check("src_oor_error", {31'd0, error}, 32'd1);
    check("src_oor_access", wr_cnt + rd_cnt, 32'd0);
    check("src_oor_mem0", mem[0], 32'd1);

    // COPY of 8 with abort during the 3rd READ (sample 5)
    launch(1'b0, 40, 60, 8, 32'h0);
    wait_done(5);
    check("abort_error", {31'd0, error}, 32'd0);
    check("abort_wr_cnt", wr_cnt, 32'd3);
    check("abort_checksum", checksum, 32'h303);
    check("abort_mem60", mem[60], 32'h100);
    check("abort_mem62", mem[62], 32'h102);
    check("abort_mem63", mem[63], 32'hA5A5_0003);
    check("abort_mem67", mem[67], 32'hA5A5_0007);

    // Reset in the middle of a 16-word FILL at 100
    launch(1'b1, 0, 100, 16, 32'h5A5A5A5A);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {27'd0, busy, done, error, Wren, Rden}, 32'd0);
    check("mid_rst_waddr_raddr", {12'd0, Waddr, Raddr}, 32'd0);
    check("mid_rst_wdata", Wdata, 32'd0);
    check("mid_rst_checksum", checksum, 32'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_no_done", {31'd0, done}, 32'd0);
    check("mid_rst_mem102", mem[102], 32'h5A5A5A5A);
    check("mid_rst_mem103", mem[103], 32'h0);
    rst_n = 1'b1;
    launch(1'b1, 0, 103, 1, 32'h0BADCAFE);
    wait_done(0);
    check("post_rst_done_cyc", done_cyc, 32'd2);
    check("post_rst_mem103", mem[103], 32'h0BADCAFE);
    check("post_rst_checksum", checksum, 32'h0BADCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dma_engine.md
Name: mem_dma_engine

Overview:
- Memory-side initiator that drives the write port and one read port of the single-cycle ideal memory.
- Performs word block COPY (src -> dst) and FILL (constant -> dst) without the CPU, then reports completion and a 32-bit additive checksum of the written words.
- Sits beside the multi-cycle MIPS core; its read and write port signals are muxed onto the memory ports by the top level while busy is high.

Parameters:
- ADDR_WIDTH, 10, memory byte-address width; word index width is ADDR_WIDTH-2.
- MEM_WORDS, 2**(ADDR_WIDTH-2), number of 32-bit words in the memory.

Ports:
- clk  in  1  source clock of the MIPS CPU Evaluation Module.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that launches an operation; sampled only in IDLE.
- mode  in  1  0 = COPY, 1 = FILL.
- src_idx  in  ADDR_WIDTH-2  source word index (COPY only).
- dst_idx  in  ADDR_WIDTH-2  destination word index.
- length  in  ADDR_WIDTH-1  word count, 0..MEM_WORDS.
- fill_data  in  32  constant written in FILL mode.
- abort  in  1  stops the operation after the current word.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky range-error flag; cleared by the next accepted start.
- checksum  out  32  modulo-2^32 sum of all words written.
- Waddr  out  ADDR_WIDTH  memory write address (word index, zero-extended).
- Wren  out  1  memory write enable.
- Wdata  out  32  memory write data.
- Raddr  out  ADDR_WIDTH  memory read address (word index, zero-extended).
- Rden  out  1  memory read enable.
- Rdata  in  32  memory read data; combinational from Raddr.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, error, Wren, Rden = 0; Waddr, Raddr, Wdata = 0; checksum = 0; internal counters = 0. Deassertion takes effect at the next clk edge.
- States are IDLE, READ, WRITE, FINISH.
- IDLE, start=1:
  - Latch all operands and clear error and checksum.
  - If length==0: go to FINISH with no memory access.
  - If dst_idx+length > MEM_WORDS, or (COPY and src_idx+length > MEM_WORDS): set error and go to FINISH with no memory access.
  - Otherwise go to READ for COPY, or WRITE for FILL.
- READ (COPY only):
  - Rden=1, Raddr=current src.
  - Rdata is captured into the data buffer at the clock edge; then go to WRITE.
- WRITE:
  - Wren=1, Waddr=current dst, Wdata=buffer (COPY) or fill_data (FILL).
  - On the edge: checksum += Wdata; src and dst increment; remaining decrements.
  - Next state: if remaining becomes 0 or abort=1, go to FINISH. Otherwise go to READ (COPY) or stay in WRITE (FILL).
- Throughput: COPY takes 2 cycles per word; FILL takes 1 cycle per word.
- FINISH: done=1 for exactly one cycle, busy=0 next, return to IDLE.
- busy is high in READ and WRITE, and on the FINISH cycle.
- Rden, Wren, Raddr and Waddr are registered/decoded from state only, so they are glitch-free and never both asserted in the same cycle.
- abort:
  - In READ it is ignored until the following WRITE completes, so a word is never half-moved.
  - In IDLE it is ignored.
- start while busy is ignored.
- Overlap: COPY is strictly ascending. For overlapping ranges with dst>src, the result is a defined forward copy that re-reads already-written words; this is not an error.
- Indices never wrap, because the range check rejects any operation that would exceed MEM_WORDS.
- Reset mid-operation aborts immediately. Memory contents already written remain; no done pulse is issued.
- checksum holds its value after FINISH until the next accepted start.

Decomposition:
- Shared package (or a header of defines): state encodings ST_IDLE, ST_READ, ST_WRITE, ST_FINISH, and mode constants MODE_COPY=0, MODE_FILL=1.
- No sub-module is required. The range check may be factored into dma_range_chk, a combinational block on the latched operands.

Test Plan:
- FILL dst=8, len=4, data=0xDEADBEEF -> mem[8..11]=0xDEADBEEF; Wren high 4 consecutive cycles; done after 4 busy cycles; checksum=0x7AB6FBBC.
- COPY src=0 (preload 1,2,3), dst=20, len=3 -> mem[20..22]=1,2,3; Rden and Wren alternate, never together; checksum=6; busy high for 6 cycles, then FINISH.
- len=0 -> done the cycle after start; no Wren or Rden; error=0; checksum=0.
- FILL dst=250, len=10 (MEM_WORDS=256) -> error=1 and done pulse; no memory write; error clears on the next valid start.
- COPY len=8 with abort pulsed during the 3rd READ -> exactly 3 words written; done asserted; remaining destination words unchanged.
- Drop rst_n during a FILL of len=16 -> all outputs 0 immediately; only the words written before reset have changed; a new start after reset works.
